// File: rtl/alarm_controller.sv
// alarm_controller: alarm ring/snooze/stop sequencer; define ALARM_ZERO_IS_OFF_EN to treat alarm 00:00:00 as "no alarm"
module alarm_controller #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S = 300,
  parameter int MAX_SNOOZES = 3,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic [23:0] current_time,
  input  logic [23:0] intended_alarm,
  input  logic        alarm_enable,
  input  logic        setting_active,
  input  logic        snooze_pulse,
  input  logic        stop_pulse,
  output logic        buzzer,
  output logic        ringing,
  output logic        snoozing,
  output logic        missed,
  output logic [1:0]  snooze_left
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE, HOLD} state_t;
  localparam logic [1:0] SL_INIT = 2'((MAX_SNOOZES > 3) ? 3 : MAX_SNOOZES);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] sec_cnt, cnt_n;
  logic beep_phase, beep_n, missed_n, match, trigger, off;
  logic [1:0] sl_n;
  assign match = current_time == intended_alarm;
  assign off = setting_active | !alarm_enable;
`ifdef ALARM_ZERO_IS_OFF_EN
  assign trigger = !off & match & (|intended_alarm);
`else
  assign trigger = !off & match;
`endif
  always_comb begin
    state_n = state;
    cnt_n = sec_cnt;
    beep_n = beep_phase;
    sl_n = snooze_left;
    missed_n = missed & !stop_pulse;
    if (off) state_n = IDLE;
    else case (state)
      IDLE: if (trigger) begin
        state_n = RING;
        beep_n = 1'b1;
        sl_n = SL_INIT;
      end
      RING: if (stop_pulse) state_n = HOLD;
      else if (snooze_pulse) begin
        state_n = (snooze_left != 2'd0) ? SNOOZE : HOLD;
        sl_n = (snooze_left != 2'd0) ? snooze_left - 2'd1 : snooze_left;
      end else if (tick_1hz) begin
        if (sec_cnt == RING_LAST) begin
          state_n = HOLD;
          missed_n = 1'b1;
        end else begin
          cnt_n = sec_cnt + 1'b1;
          beep_n = !beep_phase;
        end
      end
      SNOOZE: if (stop_pulse) state_n = HOLD;
      else if (tick_1hz) begin
        if (sec_cnt == SNOOZE_LAST) begin
          state_n = RING;
          beep_n = 1'b1;
        end else cnt_n = sec_cnt + 1'b1;
      end
      HOLD: if (!match) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // every state change restarts the second counter, so it can never wrap
    if (state_n != state) cnt_n = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sec_cnt <= '0;
      beep_phase <= 1'b0;
      snooze_left <= SL_INIT;
      missed <= 1'b0;
      buzzer <= 1'b0;
      ringing <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      state <= state_n;
      sec_cnt <= cnt_n;
      beep_phase <= beep_n;
      snooze_left <= sl_n;
      missed <= missed_n;
      buzzer <= (state_n == RING) & beep_n;
      ringing <= state_n == RING;
      snoozing <= state_n == SNOOZE;
    end
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed self-checking bench for alarm_controller
module tb_alarm_controller;
  logic clk = 0, rst_n = 0, tick_1hz = 0, alarm_enable = 0, setting_active = 0;
  logic snooze_pulse = 0, stop_pulse = 0;
  logic [23:0] current_time = 24'h000000, intended_alarm = 24'h000000;
  logic buzzer, ringing, snoozing, missed;
  logic [1:0] snooze_left;
  int n_chk = 0, n_fail = 0;

  alarm_controller #(.RING_TIMEOUT_S(4), .SNOOZE_S(5), .MAX_SNOOZES(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .current_time(current_time),
    .intended_alarm(intended_alarm), .alarm_enable(alarm_enable),
    .setting_active(setting_active), .snooze_pulse(snooze_pulse), .stop_pulse(stop_pulse),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .missed(missed),
    .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1;
    cyc();
    tick_1hz = 0;
  endtask

  task automatic stop();
    stop_pulse = 1;
    cyc();
    stop_pulse = 0;
  endtask

  task automatic snooze();
    snooze_pulse = 1;
    cyc();
    snooze_pulse = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  task automatic arm_and_trigger();
    intended_alarm = 24'h123000;
    alarm_enable = 1;
    current_time = 24'h122959;
    cyc();
    current_time = 24'h123000;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 0;
    cyc();
    n_chk++;
    if ({buzzer, ringing, snoozing, missed, snooze_left} !== 6'b000011) begin
      n_fail++;
      $display("FAIL reset: got bz=%b rg=%b sz=%b ms=%b sl=%0d want 0 0 0 0 3", buzzer, ringing, snoozing, missed, snooze_left);
    end
    rst_n = 1;
  endtask

  task automatic test_trigger();
    intended_alarm = 24'h123000;
    alarm_enable = 1;
    current_time = 24'h122959;
    cyc();
    n_chk++;
    if (ringing !== 1'b0) begin n_fail++; $display("FAIL pre_match_ring: got %b want 0", ringing); end
    current_time = 24'h123000;
    cyc();
    n_chk++;
    if ({ringing, buzzer} !== 2'b11) begin n_fail++; $display("FAIL trig_ring_bz: got %b%b want 11", ringing, buzzer); end
    tick();
    n_chk++;
    if ({ringing, buzzer} !== 2'b10) begin n_fail++; $display("FAIL bz_toggle1: got %b%b want 10", ringing, buzzer); end
    tick();
    n_chk++;
    if ({ringing, buzzer} !== 2'b11) begin n_fail++; $display("FAIL bz_toggle2: got %b%b want 11", ringing, buzzer); end
  endtask

  task automatic test_hold();
    stop();
    n_chk++;
    if ({ringing, buzzer} !== 2'b00) begin n_fail++; $display("FAIL hold_stop: got %b%b want 00", ringing, buzzer); end
    repeat (3) cyc();
    tick();
    n_chk++;
    if (ringing !== 1'b0) begin n_fail++; $display("FAIL hold_no_rering: got %b want 0", ringing); end
    current_time = 24'h123001;
    cyc();
    cyc();
    current_time = 24'h123000;
    cyc();
    n_chk++;
    if (ringing !== 1'b1) begin n_fail++; $display("FAIL hold_next_match: got %b want 1", ringing); end
    stop();
    current_time = 24'h123001;
    cyc();
  endtask

  task automatic test_snooze();
    do_reset();
    arm_and_trigger();
    n_chk++;
    if ({ringing, snooze_left} !== 3'b111) begin n_fail++; $display("FAIL snz_start: got rg=%b sl=%0d want 1 3", ringing, snooze_left); end
    for (int i = 0; i < 3; i++) begin
      snooze();
      n_chk++;
      if ({snoozing, ringing, buzzer, snooze_left} !== {3'b100, 2'(2 - i)}) begin
        n_fail++;
        $display("FAIL snz_enter%0d: got sz=%b rg=%b bz=%b sl=%0d want 1 0 0 %0d", i, snoozing, ringing, buzzer, snooze_left, 2 - i);
      end
      repeat (4) tick();
      n_chk++;
      if ({snoozing, ringing} !== 2'b10) begin n_fail++; $display("FAIL snz_wait%0d: got sz=%b rg=%b want 1 0", i, snoozing, ringing); end
      tick();
      n_chk++;
      if ({snoozing, ringing, buzzer} !== 3'b011) begin n_fail++; $display("FAIL snz_rering%0d: got sz=%b rg=%b bz=%b want 0 1 1", i, snoozing, ringing, buzzer); end
    end
    snooze();
    n_chk++;
    if ({snoozing, ringing, snooze_left} !== 4'b0000) begin n_fail++; $display("FAIL snz_exhausted: got sz=%b rg=%b sl=%0d want 0 0 0", snoozing, ringing, snooze_left); end
    current_time = 24'h123001;
    cyc();
  endtask

  task automatic test_timeout();
    do_reset();
    arm_and_trigger();
    repeat (3) tick();
    n_chk++;
    if ({ringing, missed} !== 2'b10) begin n_fail++; $display("FAIL to_before: got rg=%b ms=%b want 1 0", ringing, missed); end
    tick();
    n_chk++;
    if ({ringing, buzzer, missed} !== 3'b001) begin n_fail++; $display("FAIL to_expire: got rg=%b bz=%b ms=%b want 0 0 1", ringing, buzzer, missed); end
    stop();
    n_chk++;
    if (missed !== 1'b0) begin n_fail++; $display("FAIL to_stop_clear: got %b want 0", missed); end
    current_time = 24'h123001;
    cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    arm_and_trigger();
    stop_pulse = 1;
    snooze_pulse = 1;
    cyc();
    stop_pulse = 0;
    snooze_pulse = 0;
    n_chk++;
    if ({ringing, snoozing, snooze_left} !== 4'b0011) begin n_fail++; $display("FAIL stop_and_snz: got rg=%b sz=%b sl=%0d want 0 0 3", ringing, snoozing, snooze_left); end
    current_time = 24'h123001;
    cyc();
    arm_and_trigger();
    snooze();
    setting_active = 1;
    cyc();
    n_chk++;
    if ({ringing, snoozing, buzzer} !== 3'b000) begin n_fail++; $display("FAIL setting_override: got rg=%b sz=%b bz=%b want 0 0 0", ringing, snoozing, buzzer); end
    cyc();
    n_chk++;
    if (ringing !== 1'b0) begin n_fail++; $display("FAIL setting_no_trig: got %b want 0", ringing); end
    current_time = 24'h123001;
    cyc();
    setting_active = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    arm_and_trigger();
    repeat (4) tick();
    current_time = 24'h123001;
    cyc();
    arm_and_trigger();
    snooze();
    snooze_pulse = 0;
    current_time = 24'h123001;
    repeat (5) tick();
    n_chk++;
    if ({ringing, missed, snooze_left} !== 4'b1110) begin n_fail++; $display("FAIL pre_rst_state: got rg=%b ms=%b sl=%0d want 1 1 2", ringing, missed, snooze_left); end
    rst_n = 0;
    cyc();
    n_chk++;
    if ({buzzer, ringing, snoozing, missed, snooze_left} !== 6'b000011) begin
      n_fail++;
      $display("FAIL rst_mid_ring: got bz=%b rg=%b sz=%b ms=%b sl=%0d want 0 0 0 0 3", buzzer, ringing, snoozing, missed, snooze_left);
    end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_zero_alarm();
    logic exp;
`ifdef ALARM_ZERO_IS_OFF_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    do_reset();
    alarm_enable = 1;
    intended_alarm = 24'h000000;
    current_time = 24'h235959;
    cyc();
    current_time = 24'h000000;
    cyc();
    n_chk++;
    if (ringing !== exp) begin n_fail++; $display("FAIL zero_alarm: got %b want %b", ringing, exp); end
    alarm_enable = 0;
    cyc();
    n_chk++;
    if (ringing !== 1'b0) begin n_fail++; $display("FAIL disable_idle: got %b want 0", ringing); end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_hold();
    test_snooze();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_zero_alarm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
